// File: rtl/vote_tally_ctrl.sv
// Vote tally sequencer: one-hot button press -> shared incrementer -> per-candidate
// counter, with multi-press rejection, saturation detect and registered readout.

module vote_cnt_lane #(
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             we,
  input  logic [CNT_W-1:0] wdata,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (we) cnt_d = wdata;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;

  assign cnt = cnt_q;
endmodule

module vote_tally_ctrl #(
  parameter int NUM_CAND = 4,
  parameter int CNT_W    = 10,
  parameter int SEL_W    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                voting_en,
  input  logic                clear,
  input  logic [NUM_CAND-1:0] vote_btn,
  output logic [CNT_W-1:0]    adder_in,
  input  logic [CNT_W-1:0]    adder_out,
  input  logic [SEL_W-1:0]    result_sel,
  output logic [CNT_W-1:0]    result_count,
  output logic                busy,
  output logic                vote_done,
  output logic                invalid_vote,
  output logic                overflow
);
  typedef enum logic [1:0] {IDLE, INC, RELEASE} state_t;

  state_t                         state_q, state_d;
  logic [SEL_W-1:0]               idx_q, idx_d;
  logic                           done_q, done_d;
  logic                           inval_q, inval_d;
  logic                           ovf_q, ovf_d;
  logic [CNT_W-1:0]               rd_q, rd_d;

  logic [NUM_CAND-1:0][CNT_W-1:0] cnt;
  logic [NUM_CAND-1:0]            we;
  logic [SEL_W-1:0]               btn_idx;
  logic [CNT_W-1:0]               cur_cnt;
  logic                           sat, clr_ok;

  always_comb begin
    btn_idx = '0;
    cur_cnt = '0;
    rd_d    = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (vote_btn[i])             btn_idx = SEL_W'(i);
      if (idx_q == SEL_W'(i))      cur_cnt = cnt[i];
      // out-of-range selects match no lane and read back 0
      if (result_sel == SEL_W'(i)) rd_d    = cnt[i];
    end
  end

  assign sat      = &cur_cnt;
  assign clr_ok   = (state_q == IDLE) && !voting_en && clear;
  assign adder_in = (state_q == INC) ? cur_cnt : '0;

  always_comb begin
    for (int i = 0; i < NUM_CAND; i++)
      we[i] = (state_q == INC) && !sat && (idx_q == SEL_W'(i));
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    inval_d = 1'b0;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (clr_ok) ovf_d = 1'b0;
        if (voting_en && |vote_btn) begin
          if ($onehot(vote_btn)) begin
            idx_d   = btn_idx;
            state_d = INC;
          end else begin
            inval_d = 1'b1;
            state_d = RELEASE;
          end
        end
      end
      INC: begin
        if (sat) ovf_d  = 1'b1;
        else     done_d = 1'b1;
        state_d = RELEASE;
      end
      RELEASE: if (vote_btn == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
      inval_q <= 1'b0;
      ovf_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      inval_q <= inval_d;
      ovf_q   <= ovf_d;
      rd_q    <= rd_d;
    end

  for (genvar g = 0; g < NUM_CAND; g++) begin : g_lane
    vote_cnt_lane #(.CNT_W(CNT_W)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr_ok),
      .we    (we[g]),
      .wdata (adder_out),
      .cnt   (cnt[g])
    );
  end

  assign busy         = (state_q != IDLE);
  assign vote_done    = done_q;
  assign invalid_vote = inval_q;
  assign overflow     = ovf_q;
  assign result_count = rd_q;
endmodule
